// File: rtl/text_overlay_screen_pkg.sv
// Shared VGA bus layout, font cell constants and the message/font ROM contents for the text overlay.
// Pure declarations and lookup functions: no state, no latency, no flow control.
package text_overlay_screen_pkg;

  localparam int VGA_BUS_SIZE = 38;
  localparam int CHAR_W       = 8;
  localparam int CHAR_H       = 16;

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_t;

  typedef enum logic [1:0] {
    MODE_SOLID   = 2'b00,
    MODE_BLINK   = 2'b01,
    MODE_INVERSE = 2'b10,
    MODE_TRANSP  = 2'b11
  } mode_e;

  localparam logic [6:0] CODE_BLANK = 7'h20;

  // Leftmost character of each row sits in the most significant byte.
  function automatic logic [6:0] msg_char(input logic [2:0] msg, input logic [2:0] row,
                                          input logic [4:0] col);
    logic [127:0] str;
    logic [6:0]   base;
    case ({msg, row})
      6'o00:   str = "ABOX XOBA AXBO A";
      6'o01:   str = "XXOO BBAA OXOX B";
      6'o10:   str = "BOXA AXOB  OA BX";
      6'o11:   str = "OOOO XXXX AAAA B";
      6'o20:   str = "XAXA BOBO  XO AB";
      6'o21:   str = " A B O X A B O X";
      6'o30:   str = "AAAABBBBOOOOXXXX";
      6'o31:   str = "X O A B X O A B ";
      default: str = {16{8'h20}};
    endcase
    base = {4'd15 - col[3:0], 3'b000};
    msg_char = col[4] ? CODE_BLANK : str[base +: 7];
  endfunction

  // Glyph line 0 is the top scan line and is stored in the most significant byte.
  function automatic logic [7:0] font_line(input logic [6:0] code, input logic [3:0] line);
    logic [127:0] glyph;
    case (code)
      7'h41:   glyph = 128'h183C_6666_7E66_6666_6600_0000_0000_0000;
      7'h42:   glyph = 128'h7C66_667C_6666_667C_0000_0000_0000_0000;
      7'h4F:   glyph = 128'h3C66_6666_6666_663C_0000_0000_0000_0000;
      7'h58:   glyph = 128'hC366_3C18_183C_66C3_0000_0000_0000_0000;
      default: glyph = '0;
    endcase
    font_line = glyph[{~line, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/text_overlay_screen_msg_rom.sv
// Paged message ROM: {msg,row,col} -> 7-bit character code, blank for pages beyond MSG_COUNT.
// Registered output, 1 pclk latency; no backpressure.
module text_overlay_screen_msg_rom
  import text_overlay_screen_pkg::*;
#(
  parameter int MSG_COUNT = 4
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic [2:0] i_msg,
  input  logic [2:0] i_row,
  input  logic [4:0] i_col,
  output logic [6:0] o_code
);

  localparam logic [3:0] MSG_LIMIT = 4'(MSG_COUNT);

  logic [6:0] r_code;

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_code <= '0;
    end else begin
      r_code <= ({1'b0, i_msg} >= MSG_LIMIT) ? CODE_BLANK : msg_char(i_msg, i_row, i_col);
    end
  end

  assign o_code = r_code;

endmodule

// File: rtl/text_overlay_screen.sv
// Text box overlay on the VGA pixel bus with scaling, blink, inverse and transparent modes.
// Fixed 3 pclk latency on every bus field; free-running, no backpressure.
module text_overlay_screen
  import text_overlay_screen_pkg::*;
#(
  parameter int          XPOS         = 256,
  parameter int          YPOS         = 300,
  parameter int          COLS         = 16,
  parameter int          ROWS         = 2,
  parameter int          SCALE_LOG2   = 1,
  parameter int          MSG_COUNT    = 4,
  parameter logic [11:0] FG_RGB       = 12'hFFF,
  parameter logic [11:0] BG_RGB       = 12'h000,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic                    pclk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [1:0]              mode,
  input  logic [2:0]              msg_sel,
  input  logic [VGA_BUS_SIZE-1:0] vga_in,
  output logic [VGA_BUS_SIZE-1:0] vga_out,
  output logic [7:0]              frame_cnt
);

  localparam int          BOX_W      = COLS * (CHAR_W << SCALE_LOG2);
  localparam int          BOX_H      = ROWS * (CHAR_H << SCALE_LOG2);
  localparam logic [11:0] X_LO       = 12'(XPOS);
  localparam logic [11:0] X_HI       = 12'(XPOS + BOX_W);
  localparam logic [11:0] Y_LO       = 12'(YPOS);
  localparam logic [11:0] Y_HI       = 12'(YPOS + BOX_H);
  localparam int          BW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  vga_t        w_vin;
  logic        w_frame_start, w_in_box, w_blink_wrap;
  logic        w_en_eff, w_hidden_eff;
  mode_e       w_mode_eff;
  logic [2:0]  w_msg_eff;
  logic [10:0] w_rx, w_ry;
  logic [4:0]  w_col;
  logic [2:0]  w_row, w_xbit;
  logic [3:0]  w_line;
  logic [6:0]  w_code;
  logic        w_pix;
  logic [11:0] w_rgb;

  logic          r_en, r_hidden;
  mode_e         r_mode;
  logic [2:0]    r_msg;
  logic [BW-1:0] r_blink_cnt;
  logic [7:0]    r_frame_cnt;

  vga_t       r_s1_bus, r_s2_bus, r_out;
  logic       r_s1_in_box, r_s1_en, r_s1_hidden, r_s2_in_box, r_s2_en, r_s2_hidden;
  mode_e      r_s1_mode, r_s2_mode;
  logic [2:0] r_s1_xbit, r_s2_xbit;
  logic [3:0] r_s1_line;
  logic [7:0] r_s2_font;

  assign w_vin         = vga_t'(vga_in);
  assign w_frame_start = (w_vin.hcount == '0) && (w_vin.vcount == '0);
  assign w_blink_wrap  = (r_blink_cnt == BLINK_LAST);

  // The frame-start pixel already belongs to the new frame, so it sees the freshly sampled controls.
  assign w_en_eff     = w_frame_start ? enable : r_en;
  assign w_mode_eff   = w_frame_start ? mode_e'(mode) : r_mode;
  assign w_msg_eff    = w_frame_start ? msg_sel : r_msg;
  assign w_hidden_eff = w_frame_start ? (r_hidden ^ w_blink_wrap) : r_hidden;

  assign w_in_box = ({1'b0, w_vin.hcount} >= X_LO) && ({1'b0, w_vin.hcount} < X_HI) &&
                    ({1'b0, w_vin.vcount} >= Y_LO) && ({1'b0, w_vin.vcount} < Y_HI);
  assign w_rx   = w_vin.hcount - 11'(XPOS);
  assign w_ry   = w_vin.vcount - 11'(YPOS);
  assign w_col  = 5'(w_rx >> (3 + SCALE_LOG2));
  assign w_row  = 3'(w_ry >> (4 + SCALE_LOG2));
  assign w_xbit = 3'(w_rx >> SCALE_LOG2);
  assign w_line = 4'(w_ry >> SCALE_LOG2);

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_en        <= 1'b0;
      r_mode      <= MODE_SOLID;
      r_msg       <= '0;
      r_blink_cnt <= '0;
      r_hidden    <= 1'b0;
      r_frame_cnt <= '0;
    end else if (w_frame_start) begin
      r_en        <= enable;
      r_mode      <= mode_e'(mode);
      r_msg       <= msg_sel;
      r_hidden    <= w_hidden_eff;
      r_blink_cnt <= w_blink_wrap ? '0 : r_blink_cnt + 1'b1;
      r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  text_overlay_screen_msg_rom #(
    .MSG_COUNT(MSG_COUNT)
  ) u_msg_rom (
    .pclk  (pclk),
    .rst   (rst),
    .i_msg (w_msg_eff),
    .i_row (w_row),
    .i_col (w_col),
    .o_code(w_code)
  );

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_s1_bus    <= '0;
      r_s1_in_box <= 1'b0;
      r_s1_en     <= 1'b0;
      r_s1_hidden <= 1'b0;
      r_s1_mode   <= MODE_SOLID;
      r_s1_xbit   <= '0;
      r_s1_line   <= '0;
      r_s2_bus    <= '0;
      r_s2_in_box <= 1'b0;
      r_s2_en     <= 1'b0;
      r_s2_hidden <= 1'b0;
      r_s2_mode   <= MODE_SOLID;
      r_s2_xbit   <= '0;
      r_s2_font   <= '0;
      r_out       <= '0;
    end else begin
      r_s1_bus    <= w_vin;
      r_s1_in_box <= w_in_box;
      r_s1_en     <= w_en_eff;
      r_s1_hidden <= w_hidden_eff;
      r_s1_mode   <= w_mode_eff;
      r_s1_xbit   <= w_xbit;
      r_s1_line   <= w_line;
      r_s2_bus    <= r_s1_bus;
      r_s2_in_box <= r_s1_in_box;
      r_s2_en     <= r_s1_en;
      r_s2_hidden <= r_s1_hidden;
      r_s2_mode   <= r_s1_mode;
      r_s2_xbit   <= r_s1_xbit;
      r_s2_font   <= font_line(w_code, r_s1_line);
      r_out       <= r_s2_bus;
      r_out.rgb   <= w_rgb;
    end
  end

  assign w_pix = r_s2_font[3'd7 - r_s2_xbit];

  always_comb begin
    w_rgb = r_s2_bus.rgb;
    if (r_s2_in_box && r_s2_en && !r_s2_bus.hblnk && !r_s2_bus.vblnk) begin
      case (r_s2_mode)
        MODE_SOLID:   w_rgb = w_pix ? FG_RGB : BG_RGB;
        MODE_BLINK:   w_rgb = (w_pix && !r_s2_hidden) ? FG_RGB : BG_RGB;
        MODE_INVERSE: w_rgb = w_pix ? BG_RGB : FG_RGB;
        MODE_TRANSP:  w_rgb = w_pix ? FG_RGB : r_s2_bus.rgb;
        default:      w_rgb = r_s2_bus.rgb;
      endcase
    end
  end

  assign vga_out   = r_out;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_text_overlay_screen.sv
// Randomized scoreboard bench for text_overlay_screen against a behavioural pixel model.
module tb_text_overlay_screen;

  localparam int          XPOS  = 256;
  localparam int          YPOS  = 300;
  localparam int          COLS  = 16;
  localparam int          ROWS  = 2;
  localparam int          S     = 1;
  localparam int          MSGN  = 4;
  localparam int          BLINK = 2;
  localparam logic [11:0] FG    = 12'hFFF;
  localparam logic [11:0] BG    = 12'h000;
  localparam int          SC    = 1 << S;
  localparam int          BOX_W = COLS * 8 * SC;
  localparam int          BOX_H = ROWS * 16 * SC;

  logic        pclk = 1'b0;
  logic        rst;
  logic        enable;
  logic [1:0]  mode;
  logic [2:0]  msg_sel;
  logic [37:0] vin;
  logic [37:0] vga_out;
  logic [7:0]  frame_cnt;

  text_overlay_screen #(
    .XPOS(XPOS), .YPOS(YPOS), .COLS(COLS), .ROWS(ROWS), .SCALE_LOG2(S),
    .MSG_COUNT(MSGN), .FG_RGB(FG), .BG_RGB(BG), .BLINK_FRAMES(BLINK)
  ) dut (
    .pclk(pclk), .rst(rst), .enable(enable), .mode(mode), .msg_sel(msg_sel),
    .vga_in(vin), .vga_out(vga_out), .frame_cnt(frame_cnt)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    int          due;
    logic [37:0] val;
  } sb_t;

  sb_t   sb[$];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  string msgs[4][2];

  int m_fc, m_en, m_mode, m_msg;

  always @(posedge pclk) cyc <= cyc + 1;

  function automatic logic [7:0] glyph(input byte unsigned c, input int ln);
    logic [7:0] g[16];
    case (c)
      8'h41: g = '{8'h18,8'h3C,8'h66,8'h66,8'h7E,8'h66,8'h66,8'h66,8'h66,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00};
      8'h42: g = '{8'h7C,8'h66,8'h66,8'h7C,8'h66,8'h66,8'h66,8'h7C,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00};
      8'h4F: g = '{8'h3C,8'h66,8'h66,8'h66,8'h66,8'h66,8'h66,8'h3C,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00};
      8'h58: g = '{8'hC3,8'h66,8'h3C,8'h18,8'h18,8'h3C,8'h66,8'hC3,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00};
      default: g = '{default: 8'h00};
    endcase
    return g[ln];
  endfunction

  function automatic logic [37:0] model(input logic [10:0] h, input logic [10:0] v, input logic hs,
                                        input logic vs, input logic hb, input logic vb,
                                        input logic [11:0] rgb);
    int          hi, vi, rx, ry, col, row, xb, ln;
    byte unsigned ch;
    logic [7:0]  g;
    bit          pix, hid, inb;
    logic [11:0] o;
    hi  = int'(h);
    vi  = int'(v);
    inb = (hi >= XPOS) && (hi < XPOS + BOX_W) && (vi >= YPOS) && (vi < YPOS + BOX_H);
    o   = rgb;
    if (inb && m_en != 0 && !hb && !vb) begin
      rx  = hi - XPOS;
      ry  = vi - YPOS;
      col = rx / (8 * SC);
      row = ry / (16 * SC);
      xb  = (rx / SC) % 8;
      ln  = (ry / SC) % 16;
      ch  = (m_msg < MSGN) ? msgs[m_msg][row].getc(col) : 8'h20;
      g   = glyph(ch, ln);
      pix = g[7 - xb];
      hid = ((m_fc / BLINK) % 2) == 1;
      case (m_mode)
        0: o = pix ? FG : BG;
        1: o = (pix && !hid) ? FG : BG;
        2: o = pix ? BG : FG;
        default: o = pix ? FG : rgb;
      endcase
    end
    return {h, v, hs, vs, hb, vb, o};
  endfunction

  task automatic pix(input logic [10:0] h, input logic [10:0] v, input logic hb, input logic vb,
                     input logic [11:0] rgb);
    logic hs, vs;
    bit   fs;
    sb_t  e;
    hs  = 1'($urandom);
    vs  = 1'($urandom);
    vin = {h, v, hs, vs, hb, vb, rgb};
    fs  = (h == 11'd0) && (v == 11'd0);
    if (fs) begin
      m_fc++;
      m_en   = int'(enable);
      m_mode = int'(mode);
      m_msg  = int'(msg_sel);
    end
    e.due = cyc + 3;
    e.val = model(h, v, hs, vs, hb, vb, rgb);
    sb.push_back(e);
    @(posedge pclk);
    #1;
    if (fs) begin
      checks++;
      if (frame_cnt !== 8'(m_fc)) begin
        errors++;
        $display("FAIL frame_cnt got %0d expected %0d", frame_cnt, 8'(m_fc));
      end
    end
  endtask

  task automatic frame_start(input logic en, input logic [1:0] md, input logic [2:0] ms);
    enable  = en;
    mode    = md;
    msg_sel = ms;
    pix(11'd0, 11'd0, 1'b0, 1'b0, 12'($urandom_range(1, 4094)));
  endtask

  // kind 0: around the box, 1: anywhere on the raster, 2: around the box over a checkerboard
  task automatic frame_body(input int kind, input int n, input bit scramble);
    for (int i = 0; i < n; i++) begin
      logic [10:0] h, v;
      logic        hb, vb;
      logic [11:0] c;
      if (kind == 1) begin
        h = 11'($urandom_range(1, 2047));
        v = 11'($urandom_range(0, 2047));
      end else begin
        h = 11'($urandom_range(XPOS - 8, XPOS + BOX_W + 8));
        v = 11'($urandom_range(YPOS - 4, YPOS + BOX_H + 4));
      end
      hb = ($urandom_range(0, 15) == 0);
      vb = ($urandom_range(0, 15) == 0);
      c  = (kind == 2) ? ((h[0] ^ v[0]) ? 12'h5A5 : 12'hA5A) : 12'($urandom);
      if (scramble && $urandom_range(0, 7) == 0) begin
        enable  = 1'($urandom);
        mode    = 2'($urandom);
        msg_sel = 3'($urandom);
      end
      pix(h, v, hb, vb, c);
    end
  endtask

  task automatic check_now(input string name, input logic [37:0] got, input logic [37:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_fc = 0; m_en = 0; m_mode = 0; m_msg = 0;
  endtask

  always @(negedge pclk) begin
    sb_t e;
    if (sb.size() != 0) begin
      if (sb[0].due <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (e.due < cyc) begin
          errors++;
          $display("FAIL pixel_late due %0d now %0d", e.due, cyc);
        end else if (vga_out !== e.val) begin
          errors++;
          $display("FAIL pixel h=%0d v=%0d got %h expected %h", e.val[37:27], e.val[26:16],
                   vga_out, e.val);
        end
      end
    end
  end

  initial begin
    msgs[0][0] = "ABOX XOBA AXBO A"; msgs[0][1] = "XXOO BBAA OXOX B";
    msgs[1][0] = "BOXA AXOB  OA BX"; msgs[1][1] = "OOOO XXXX AAAA B";
    msgs[2][0] = "XAXA BOBO  XO AB"; msgs[2][1] = " A B O X A B O X";
    msgs[3][0] = "AAAABBBBOOOOXXXX"; msgs[3][1] = "X O A B X O A B ";
    model_reset();
    rst = 1'b0; enable = 1'b0; mode = 2'b00; msg_sel = 3'd0;
    vin = {11'd5, 11'd5, 4'b1100, 12'h123};
    #2;
    check_now("reset_vga_out", vga_out, 38'd0);
    check_now("reset_frame_cnt", {30'd0, frame_cnt}, 38'd0);
    repeat (3) @(posedge pclk);
    #1 rst = 1'b1;

    // Mid-line asynchronous reset with a populated pipeline.
    frame_start(1'b0, 2'b00, 3'd0);
    frame_body(1, 40, 1'b0);
    #2 rst = 1'b0;
    sb.delete();
    #1;
    check_now("midline_reset_vga_out", vga_out, 38'd0);
    check_now("midline_reset_frame_cnt", {30'd0, frame_cnt}, 38'd0);
    model_reset();
    repeat (2) @(posedge pclk);
    #1 rst = 1'b1;
    #1;
    check_now("release_frame_cnt", {30'd0, frame_cnt}, 38'd0);

    // Blink: visible, hidden, hidden, visible, visible.
    for (int f = 0; f < 5; f++) begin
      frame_start(1'b1, 2'b01, 3'd0);
      frame_body(0, 150, 1'b1);
    end

    // Passthrough with the overlay disabled.
    frame_start(1'b0, 2'b00, 3'd0);
    frame_body(1, 300, 1'b1);

    // Geometry around the box corners and glyph replication.
    frame_start(1'b1, 2'b00, 3'd0);
    for (int v = YPOS - 1; v <= YPOS + 2; v++)
      for (int h = XPOS - 2; h < XPOS + 20; h++)
        pix(11'(h), 11'(v), 1'b0, 1'b0, 12'($urandom_range(1, 4094)));
    pix(11'(XPOS + BOX_W - 1), 11'(YPOS), 1'b0, 1'b0, 12'h777);
    pix(11'(XPOS + BOX_W), 11'(YPOS), 1'b0, 1'b0, 12'h777);
    pix(11'(XPOS), 11'(YPOS + BOX_H - 1), 1'b0, 1'b0, 12'h777);
    pix(11'(XPOS), 11'(YPOS + BOX_H), 1'b0, 1'b0, 12'h777);
    frame_body(0, 200, 1'b1);

    // Mid-frame control changes only apply from the next frame start.
    frame_start(1'b1, 2'b00, 3'd1);
    for (int v = YPOS - 4; v <= YPOS + 40; v++) begin
      if (v == 310) begin
        msg_sel = 3'd2;
        mode    = 2'b10;
      end
      for (int i = 0; i < 6; i++)
        pix(11'($urandom_range(XPOS - 4, XPOS + BOX_W + 4)), 11'(v), 1'b0, 1'b0, 12'($urandom));
    end
    frame_start(enable, mode, msg_sel);
    frame_body(0, 200, 1'b1);

    // Out-of-range page renders an empty box.
    frame_start(1'b1, 2'b00, 3'd7);
    frame_body(0, 200, 1'b1);

    frame_start(1'b1, 2'b10, 3'd3);
    frame_body(0, 200, 1'b1);
    frame_start(1'b1, 2'b11, 3'd2);
    frame_body(2, 300, 1'b1);

    for (int f = 0; f < 4; f++) begin
      frame_start(1'($urandom), 2'($urandom), 3'($urandom));
      frame_body(($urandom_range(0, 3) == 0) ? 1 : 0, 200, 1'b1);
    end

    repeat (6) @(posedge pclk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
